// File: rtl/mouse_packet_decoder.sv
// PS/2 mouse packet decoder: assembles 3-byte (or 4-byte with MOUSE_WHEEL_EN) packets,
// integrates signed deltas into clamped screen coordinates (Y grows downward).
module mouse_packet_decoder #(
  parameter int unsigned X_MAX          = 1023,
  parameter int unsigned Y_MAX          = 767,
  parameter int unsigned X_INIT         = 512,
  parameter int unsigned Y_INIT         = 384,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              left_mouse,
  output logic              right_mouse,
  output logic              middle_mouse,
  output logic [11:0]       xpos,
  output logic [11:0]       ypos,
  output logic              pkt_valid,
  output logic              sync_err
`ifdef MOUSE_WHEEL_EN
  ,
  output logic signed [3:0] wheel_delta
`endif
);

  localparam int unsigned POS_W = 12;
  localparam int unsigned SUM_W = 14;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic signed [SUM_W-1:0] X_MAX_S  = SUM_W'(X_MAX);
  localparam logic signed [SUM_W-1:0] Y_MAX_S  = SUM_W'(Y_MAX);

  typedef enum logic [1:0] {
    S_B0 = 2'd0,
    S_B1 = 2'd1,
    S_B2 = 2'd2,
    S_B3 = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_btn;
  logic [1:0]       r_sgn;
  logic [1:0]       r_ovf;
  logic [7:0]       r_dx_lo;
  logic [7:0]       w_dy_lo;
  logic             w_hdr_ld;
  logic             w_dx_ld;
  logic             w_apply;
  logic             w_err;

`ifdef MOUSE_WHEEL_EN
  logic [7:0] r_dy_lo;
  logic       w_dy_ld;
  assign w_dy_lo = r_dy_lo;
`else
  assign w_dy_lo = rx_data;
`endif

  // Next-state and control decode, including the inter-byte timeout
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_hdr_ld    = 1'b0;
    w_dx_ld     = 1'b0;
    w_apply     = 1'b0;
    w_err       = 1'b0;
`ifdef MOUSE_WHEEL_EN
    w_dy_ld     = 1'b0;
`endif
    case (r_state)
      S_B0: begin
        if (rx_valid) begin
          if (rx_data[3]) begin
            w_hdr_ld    = 1'b1;
            w_state_nxt = S_B1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_B1: begin
        if (rx_valid) begin
          w_dx_ld     = 1'b1;
          w_state_nxt = S_B2;
        end
      end
      S_B2: begin
        if (rx_valid) begin
`ifdef MOUSE_WHEEL_EN
          w_dy_ld     = 1'b1;
          w_state_nxt = S_B3;
`else
          w_apply     = 1'b1;
          w_state_nxt = S_B0;
`endif
        end
      end
`ifdef MOUSE_WHEEL_EN
      S_B3: begin
        if (rx_valid) begin
          w_apply     = 1'b1;
          w_state_nxt = S_B0;
        end
      end
`endif
      default: w_state_nxt = S_B0;
    endcase

    // A byte arriving in the expiry cycle takes priority over the timeout
    if ((r_state != S_B0) && !rx_valid) begin
      if (r_cnt == CNT_LAST) begin
        w_state_nxt = S_B0;
        w_err       = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  // Delta extraction and clamped position update
  logic signed [8:0]       w_dx9;
  logic signed [8:0]       w_dy9;
  logic signed [SUM_W-1:0] w_dx;
  logic signed [SUM_W-1:0] w_dy;
  logic signed [SUM_W-1:0] w_x_sum;
  logic signed [SUM_W-1:0] w_y_sum;
  logic [POS_W-1:0]        w_x_new;
  logic [POS_W-1:0]        w_y_new;

  always_comb begin
    w_dx9   = {r_sgn[0], r_dx_lo};
    w_dy9   = {r_sgn[1], w_dy_lo};
    w_dx    = r_ovf[0] ? '0 : SUM_W'(w_dx9);
    w_dy    = r_ovf[1] ? '0 : SUM_W'(w_dy9);
    w_x_sum = $signed({2'b00, xpos}) + w_dx;
    w_y_sum = $signed({2'b00, ypos}) - w_dy;

    if (w_x_sum < 0)            w_x_new = '0;
    else if (w_x_sum > X_MAX_S) w_x_new = POS_W'(X_MAX);
    else                        w_x_new = POS_W'(w_x_sum);

    if (w_y_sum < 0)            w_y_new = '0;
    else if (w_y_sum > Y_MAX_S) w_y_new = POS_W'(Y_MAX);
    else                        w_y_new = POS_W'(w_y_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_B0;
      r_cnt        <= '0;
      r_btn        <= '0;
      r_sgn        <= '0;
      r_ovf        <= '0;
      r_dx_lo      <= '0;
      left_mouse   <= 1'b0;
      right_mouse  <= 1'b0;
      middle_mouse <= 1'b0;
      xpos         <= POS_W'(X_INIT);
      ypos         <= POS_W'(Y_INIT);
      pkt_valid    <= 1'b0;
      sync_err     <= 1'b0;
`ifdef MOUSE_WHEEL_EN
      r_dy_lo      <= '0;
      wheel_delta  <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      pkt_valid <= w_apply;
      sync_err  <= w_err;
      if (w_hdr_ld) begin
        r_btn <= rx_data[2:0];
        r_sgn <= rx_data[5:4];
        r_ovf <= rx_data[7:6];
      end
      if (w_dx_ld) r_dx_lo <= rx_data;
`ifdef MOUSE_WHEEL_EN
      if (w_dy_ld) r_dy_lo <= rx_data;
`endif
      if (w_apply) begin
        left_mouse   <= r_btn[0];
        right_mouse  <= r_btn[1];
        middle_mouse <= r_btn[2];
        xpos         <= w_x_new;
        ypos         <= w_y_new;
`ifdef MOUSE_WHEEL_EN
        wheel_delta  <= $signed(rx_data[3:0]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Testbench for mouse_packet_decoder: directed packets plus random byte streams
// checked cycle by cycle against a byte-queue reference model.
module tb_mouse_packet_decoder;

  localparam int T = 20;
`ifdef MOUSE_WHEEL_EN
  localparam int PKT_LEN = 4;
`else
  localparam int PKT_LEN = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        left_mouse, right_mouse, middle_mouse;
  logic [11:0] xpos, ypos;
  logic        pkt_valid, sync_err;
`ifdef MOUSE_WHEEL_EN
  logic signed [3:0] wheel_delta;
`endif

  mouse_packet_decoder #(
    .X_MAX(1023), .Y_MAX(767), .X_INIT(512), .Y_INIT(384), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .left_mouse   (left_mouse),
    .right_mouse  (right_mouse),
    .middle_mouse (middle_mouse),
    .xpos         (xpos),
    .ypos         (ypos),
    .pkt_valid    (pkt_valid),
    .sync_err     (sync_err)
`ifdef MOUSE_WHEEL_EN
    ,
    .wheel_delta  (wheel_delta)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_x, m_y, m_wheel, idle;
  bit m_l, m_r, m_m, m_pv, m_se;
  int q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int clamp(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void apply_pkt();
    logic [7:0] h;
    int dx, dy;
    h  = 8'(q[0]);
    dx = h[6] ? 0 : q[1] - (h[4] ? 256 : 0);
    dy = h[7] ? 0 : q[2] - (h[5] ? 256 : 0);
    m_l = h[0];
    m_r = h[1];
    m_m = h[2];
    m_x = clamp(m_x + dx, 1023);
    m_y = clamp(m_y - dy, 767);
    if (PKT_LEN == 4) m_wheel = q[PKT_LEN-1] & 15;
    m_pv = 1'b1;
    q.delete();
  endfunction

  function automatic void model_step(bit r, bit v, logic [7:0] d);
    m_pv = 1'b0;
    m_se = 1'b0;
    if (r) begin
      m_x = 512; m_y = 384; m_l = 0; m_r = 0; m_m = 0; m_wheel = 0;
      q.delete();
      idle = 0;
    end else if (v) begin
      idle = 0;
      if (q.size() == 0 && !d[3]) m_se = 1'b1;
      else begin
        q.push_back(int'(d));
        if (q.size() == PKT_LEN) apply_pkt();
      end
    end else if (q.size() > 0) begin
      idle++;
      if (idle >= T) begin
        q.delete();
        idle = 0;
        m_se = 1'b1;
      end
    end
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("left",   {31'd0, left_mouse},   32'(m_l));
    check("right",  {31'd0, right_mouse},  32'(m_r));
    check("middle", {31'd0, middle_mouse}, 32'(m_m));
    check("xpos",   {20'd0, xpos},         32'(m_x));
    check("ypos",   {20'd0, ypos},         32'(m_y));
    check("pkt_valid", {31'd0, pkt_valid}, 32'(m_pv));
    check("sync_err",  {31'd0, sync_err},  32'(m_se));
`ifdef MOUSE_WHEEL_EN
    check("wheel",  {28'd0, wheel_delta},  32'(m_wheel));
`endif
  endtask

  task automatic cycle(bit r, bit v, logic [7:0] d);
    rst      = r;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step(r, v, d);
    #1;
    compare_all();
  endtask

  task automatic send_pkt(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] w);
    cycle(1'b0, 1'b1, a);
    cycle(1'b0, 1'b1, b);
    cycle(1'b0, 1'b1, c);
    if (PKT_LEN == 4) cycle(1'b0, 1'b1, w);
  endtask

  initial begin
    logic [7:0] d;
    int gap, sel;
    bit r;

    // Reset
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    check("reset_x", {20'd0, xpos}, 32'd512);
    check("reset_y", {20'd0, ypos}, 32'd384);
    check("reset_btn", {29'd0, middle_mouse, right_mouse, left_mouse}, 32'd0);
    cycle(1'b0, 1'b0, 8'h00);

    // Basic packet: dx=+16, dy=+5 -> y moves up by 5
    send_pkt(8'h09, 8'h10, 8'h05, 8'h00);
    check("tp1_pv", {31'd0, pkt_valid}, 32'd1);
    check("tp1_x", {20'd0, xpos}, 32'd528);
    check("tp1_y", {20'd0, ypos}, 32'd379);
    check("tp1_left", {31'd0, left_mouse}, 32'd1);
    cycle(1'b0, 1'b0, 8'h00);
    check("tp1_pv_once", {31'd0, pkt_valid}, 32'd0);

    // Clamp X low, then saturate high
    repeat (6) send_pkt(8'h18, 8'h80, 8'h00, 8'h00);
    check("x_low", {20'd0, xpos}, 32'd0);
    repeat (5) send_pkt(8'h08, 8'hFF, 8'h00, 8'h00);
    check("x_high", {20'd0, xpos}, 32'd1023);

    // Clamp Y high (dy negative moves down), then low
    repeat (8) send_pkt(8'h28, 8'h00, 8'h00, 8'h00);
    check("y_high", {20'd0, ypos}, 32'd767);
    repeat (8) send_pkt(8'h08, 8'h00, 8'hFF, 8'h00);
    check("y_low", {20'd0, ypos}, 32'd0);
    repeat (3) send_pkt(8'h28, 8'h00, 8'h00, 8'h00);

    // Dropped byte then right-button packet
    cycle(1'b0, 1'b1, 8'h01);
    check("drop_err", {31'd0, sync_err}, 32'd1);
    send_pkt(8'h0A, 8'h00, 8'h00, 8'h00);
    check("drop_right", {31'd0, right_mouse}, 32'd1);

    // Timeout after header, then middle-button packet
    cycle(1'b0, 1'b1, 8'h08);
    repeat (T) cycle(1'b0, 1'b0, 8'h00);
    check("tmo_err", {31'd0, sync_err}, 32'd1);
    send_pkt(8'h0C, 8'h00, 8'h00, 8'h00);
    check("tmo_middle", {31'd0, middle_mouse}, 32'd1);

    // Byte arriving in the expiry cycle wins
    cycle(1'b0, 1'b1, 8'h08);
    repeat (T - 1) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h05);
    check("edge_no_err", {31'd0, sync_err}, 32'd0);
    cycle(1'b0, 1'b1, 8'h00);
    if (PKT_LEN == 4) cycle(1'b0, 1'b1, 8'h00);

    // X overflow forces dx to zero
    send_pkt(8'h48, 8'h7F, 8'h10, 8'h00);

    // Wheel packet
    send_pkt(8'h08, 8'h00, 8'h00, 8'h0F);
`ifdef MOUSE_WHEEL_EN
    check("wheel_m1", {28'd0, wheel_delta}, 32'd15);
`endif

    // Reset between second and third bytes
    cycle(1'b0, 1'b1, 8'h09);
    cycle(1'b0, 1'b1, 8'h40);
    cycle(1'b1, 1'b0, 8'h00);
    check("rst_mid_x", {20'd0, xpos}, 32'd512);
    cycle(1'b0, 1'b1, 8'h08);
    cycle(1'b0, 1'b1, 8'h0F);
    check("rst_mid_pv", {31'd0, pkt_valid}, 32'd0);
    repeat (T + 1) cycle(1'b0, 1'b0, 8'h00);

    // Random byte stream with varied gaps, occasional timeouts and resets
    for (int i = 0; i < 1500; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       gap = T - 1;
        1:       gap = T;
        2:       gap = T + 1;
        default: gap = int'($urandom_range(0, 2));
      endcase
      d = 8'($urandom);
      if (q.size() == 0 && $urandom_range(0, 4) != 0) d[3] = 1'b1;
      r = ($urandom_range(0, 199) == 0);
      repeat (gap) cycle(1'b0, 1'b0, 8'h00);
      cycle(r, 1'b1, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
